spi_slave_rx: RTL
=================

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 SHALL have ports: clk input 1, system clock; all logic on its rising edge.
REQ-002 SHALL have: rst input 1, synchronous active-high reset.
REQ-003 SHALL have: sclk input 1, SPI serial clock from the master; idles low.
REQ-004 SHALL have: cs input 1, active-low chip select from the master.
REQ-005 SHALL have: mosi input 1, serial data from the master, MSB first.
REQ-006 SHALL have: rx_data output 8, last accepted byte.
REQ-007 SHALL have: rx_valid output 1, level; high while rx_data holds an unacknowledged byte.
REQ-008 SHALL have: rx_ack input 1, one-cycle pulse from the consumer; clears rx_valid.
REQ-009 SHALL have: rx_overrun output 1, sticky; a byte was dropped.
REQ-010 SHALL have: frame_err output 1, one-cycle pulse; cs deasserted mid-byte.
REQ-011 SHALL have, only when SPI_SLAVE_MISO_EN is defined: tx_data input 8, reply byte; miso output 1, serial reply, MSB first.

Function
REQ-012 SHALL pass sclk, cs and mosi each through a 2-flop synchronizer; all edge detection uses synchronized values.
REQ-013 SHALL operate correctly when sclk high and low phases each last >= 3 clk cycles; behaviour is undefined for faster sclk.
REQ-014 SHALL implement FSM states IDLE, SHIFT, END.
REQ-015 IDLE -> SHIFT on synchronized cs falling edge; bit counter cleared to 0, shift register cleared.
REQ-016 In SHIFT, SHALL shift synchronized mosi into bit 0 of the shift register on each synchronized sclk rising edge, and increment the 3-bit bit counter.
REQ-017 On the rising edge that completes bit 8 (counter wraps 7->0), the byte is complete; the FSM stays in SHIFT to receive further bytes while cs remains low.
REQ-018 Byte completion with rx_valid=0: rx_data <= byte and rx_valid <= 1 in the next clk cycle (one clk after the synchronized 8th edge).
REQ-019 Byte completion with rx_valid=1 and no rx_ack that cycle: byte discarded, rx_data unchanged, rx_overrun <= 1.
REQ-020 Byte completion in the same cycle as rx_ack: new byte accepted, rx_valid stays 1, no overrun.
REQ-021 rx_ack with rx_valid=1 SHALL clear rx_valid next cycle and clear rx_overrun; rx_ack with rx_valid=0 SHALL be ignored.
REQ-022 SHIFT -> END on synchronized cs rising edge; END SHALL pulse frame_err for one cycle if the bit counter is nonzero, then -> IDLE unconditionally; a partial byte is never delivered.
REQ-023 sclk edges while in IDLE or END SHALL be ignored.
REQ-024 A cs falling edge in END SHALL be ignored; a new frame starts only from IDLE.

Reset
REQ-025 While rst=1: state IDLE, bit counter 0, shift register 0, rx_data 8'h00, rx_valid 0, rx_overrun 0, frame_err 0, miso 0 (if present), synchronizers 0 except cs synchronizer 1.
REQ-026 Reset mid-frame SHALL discard the partial byte without a frame_err pulse; after release the FSM waits for a fresh cs falling edge.

Configuration
REQ-027 Macro SPI_SLAVE_MISO_EN defined: tx_data SHALL be latched into a transmit register on cs falling edge and at each byte completion; miso drives its MSB, shifting left on each synchronized sclk falling edge; miso=0 while cs is high.
REQ-028 Macro SPI_SLAVE_MISO_EN undefined: tx_data and miso ports and the transmit register SHALL be absent; receive behaviour is identical.

Verification
REQ-029 Single byte: cs low, 8 bits 0xAA at sclk period 8 clk, cs high -> rx_data=0xAA, rx_valid=1, frame_err=0, rx_overrun=0.
REQ-030 Two bytes in one frame (0x3C, then 0xC3), rx_ack pulsed between them -> two deliveries 0x3C then 0xC3, no overrun.
REQ-031 Overrun: 0x11 then 0x22 with no rx_ack -> rx_data=0x11, rx_overrun=1; rx_ack clears both flags.
REQ-032 Abort: cs high after 5 bits -> frame_err one-cycle pulse, rx_valid stays 0; next full frame 0x5A delivers 0x5A.
REQ-033 Reset mid-frame after 3 bits, then full frame 0xF0 -> rx_data=0xF0, no frame_err.
REQ-034 With SPI_SLAVE_MISO_EN: tx_data=0x96, master sends 0x00 -> miso bit sequence 1,0,0,1,0,1,1,0 across the 8 sclk periods.

Source files
------------

// File: rtl/spi_slave_rx.sv
// SPI receive slave (mode 0, MSB first) with 2-flop input synchronizers and a one-byte holding register.
// Define SPI_SLAVE_MISO_EN to add the tx_data/miso reply path.
module spi_slave_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       rx_overrun,
    output logic       frame_err
`ifdef SPI_SLAVE_MISO_EN
    ,
    input  logic [7:0] tx_data,
    output logic       miso
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, END} state_t;

    logic       sclk_s1_q, sclk_s2_q, sclk_prev_q;
    logic       cs_s1_q, cs_s2_q, cs_prev_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic [1:0] fill_q;
    logic       armed_q, armed_d;

    state_t     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       byte_done;
    logic [7:0] byte_val;

`ifdef SPI_SLAVE_MISO_EN
    logic [7:0] tx_q, tx_d;
    logic       skip_q, skip_d;
`endif

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s2_q & sclk_prev_q;
    assign cs_fall   = ~cs_s2_q & cs_prev_q;
    assign cs_rise   = cs_s2_q & ~cs_prev_q;
    assign byte_val  = {shreg_q[6:0], mosi_s2_q};

    // A frame may only start after cs has been seen high through a flushed synchronizer,
    // so a reset released while cs is held low cannot fake a falling edge.
    assign armed_d = armed_q | (fill_q[1] & cs_s2_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_ovr_q    <= 1'b0;
`ifdef SPI_SLAVE_MISO_EN
            tx_q        <= '0;
            skip_q      <= 1'b0;
`endif
        end else begin
            sclk_s1_q   <= sclk;
            sclk_s2_q   <= sclk_s1_q;
            sclk_prev_q <= sclk_s2_q;
            cs_s1_q     <= cs;
            cs_s2_q     <= cs_s1_q;
            cs_prev_q   <= cs_s2_q;
            mosi_s1_q   <= mosi;
            mosi_s2_q   <= mosi_s1_q;
            fill_q      <= {fill_q[0], 1'b1};
            armed_q     <= armed_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_ovr_q    <= rx_ovr_d;
`ifdef SPI_SLAVE_MISO_EN
            tx_q        <= tx_d;
            skip_q      <= skip_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q;
        byte_done  = 1'b0;
`ifdef SPI_SLAVE_MISO_EN
        tx_d       = tx_q;
        skip_d     = skip_q;
`endif

        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                    shreg_d  = '0;
`ifdef SPI_SLAVE_MISO_EN
                    tx_d     = tx_data;
                    skip_d   = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = END;
                end else begin
                    if (sclk_rise) begin
                        shreg_d  = byte_val;
                        bitcnt_d = bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            byte_done = 1'b1;
`ifdef SPI_SLAVE_MISO_EN
                            // Reloaded MSB must survive the falling edge that closes this byte.
                            tx_d      = tx_data;
                            skip_d    = 1'b1;
`endif
                        end
                    end
`ifdef SPI_SLAVE_MISO_EN
                    if (sclk_fall) begin
                        if (skip_q) skip_d = 1'b0;
                        else        tx_d   = {tx_q[6:0], 1'b0};
                    end
`endif
                end
            end
            END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            rx_ovr_d   = 1'b0;
        end
        if (byte_done) begin
            if (!rx_valid_q || rx_ack) begin
                rx_data_d  = byte_val;
                rx_valid_d = 1'b1;
            end else begin
                rx_ovr_d   = 1'b1;
            end
        end
    end

`ifndef SPI_SLAVE_MISO_EN
    logic unused_fall;
    assign unused_fall = sclk_fall;
`endif

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = rx_ovr_q;
    assign frame_err  = (state_q == END) && (bitcnt_q != 3'd0);
`ifdef SPI_SLAVE_MISO_EN
    assign miso       = (state_q == SHIFT) ? tx_q[7] : 1'b0;
`endif

endmodule
